// File: rtl/mc_controller.sv
// mc_controller: control FSM for the multicycle RV32I core (lw, sw, R-type,
// I-type ALU, beq, jal) with a memory-ready handshake for stalls and a
// sticky halt on illegal opcodes.
//
// Ports:
//   clk, reset (async, active low)
//   op, funct3, funct7b5 : instruction fields from IR
//   Zero                 : ALU zero flag (beq)
//   mem_ready            : memory completes the current access this cycle
//   mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite : memory/strobes
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl       : datapath selects
//   retire               : pulse on the last cycle of each instruction
//   halted               : FSM is in HALT
//
// state    | meaning
// ---------+----------------------------------------------
// FETCH    | read IR at PC, PC+4; waits for mem_ready
// DECODE   | read regs, compute branch/jump target
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | data read; waits for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | data write; waits for mem_ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | write ALU result to rd
// BEQ      | compare, branch when equal
// JAL      | PC <= target, rd <= PC+4 follows in ALUWB
// HALT     | illegal opcode, left only by reset

module mc_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       retire,
  output logic       halted
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  state_t     state;
  logic       op_legal;
  logic [1:0] alu_op;
  logic       mem_req_s, irwrite_s, pcwrite_s, memwrite_s, regwrite_s, retire_s;

  assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BEQ:       state <= BEQ;
            OP_JAL:       state <= JAL;
            default:      state <= ILLEGAL_HALT ? HALT : FETCH;
          endcase
        end
        MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
        HALT:     state <= HALT;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req_s  = 1'b0;
    irwrite_s  = 1'b0;
    pcwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    retire_s   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        mem_req_s = 1'b1;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b01;
        // Illegal opcode treated as a NOP finishes here.
        retire_s = !op_legal && !ILLEGAL_HALT;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      MEMWRITE: begin
        mem_req_s  = 1'b1;
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        retire_s   = mem_ready;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = 2'b10;
        alu_op    = 2'b01;
        pcwrite_s = Zero;
        retire_s  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcwrite_s = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated by reset itself so nothing fires while reset is low,
  // even in the cycle the state register is being cleared.
  assign mem_req  = reset & mem_req_s;
  assign IRWrite  = reset & irwrite_s;
  assign PCWrite  = reset & pcwrite_s;
  assign MemWrite = reset & memwrite_s;
  assign RegWrite = reset & regwrite_s;
  assign retire   = reset & retire_s;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          // op[5] separates R-type sub from addi, which has no funct7.
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule
